fetch_align_buffer: RTL and testbench

//  Parametrised fetch realignment queue between instruction memory and the RVC expander/decoder.

---
 rtl/fetch_align_buffer_pkg.sv | 37 +++
 rtl/fetch_hword_queue.sv | 75 +++++++
 rtl/fetch_align_buffer.sv | 124 ++++++++++++
 tb/tb_fetch_align_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_align_buffer_pkg.sv
// Shared types and constants for the fetch realignment buffer.
package fetch_align_buffer_pkg;

  localparam int unsigned MaxFetchWidth = 64;

  // Low opcode bits that mark a full-length (non-compressed) instruction.
  localparam logic [1:0] opcode_rvi = 2'b11;

  // One stored halfword with the error flag of the fetch word it came from.
  typedef struct packed {
    logic [15:0] hw;
    logic        err;
  } hword_t;

  typedef struct packed {
    logic                     flush;
    logic [31:0]              flush_addr;
    logic                     fetch_valid;
    logic [MaxFetchWidth-1:0] fetch_data;
    logic                     fetch_error;
    logic                     instr_ready;
  } fetchbuf_in_type;

  typedef struct packed {
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_addr;
    logic        instr_comp;
    logic        instr_error;
  } fetchbuf_out_type;

  function automatic logic is_rvi(input logic [1:0] low_bits);
    return low_bits == opcode_rvi;
  endfunction

endpackage

// File: rtl/fetch_hword_queue.sv
// Circular halfword queue: multi-lane write, two-entry read at the head.
module fetch_hword_queue
  import fetch_align_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LANES = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned LaneCntW = $clog2(LANES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                push,
  input  logic [LaneCntW-1:0] push_cnt,
  input  hword_t [LANES-1:0]  push_hw,
  input  logic                pop,
  input  logic                pop_two,
  output hword_t              head0,
  output hword_t              head1,
  output logic [CntW-1:0]     count
);

  hword_t          mem_q [DEPTH];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nxt;
  logic [CntW-1:0] count_q, count_d, push_len, pop_len;

  // Pointer and occupancy update; clear wins over push/pop.
  always_comb begin
    push_len = push ? CntW'(push_cnt) : '0;
    pop_len  = pop ? (pop_two ? CntW'(2) : CntW'(1)) : '0;
    rd_d     = rd_q + PtrW'(pop_len);
    wr_d     = wr_q + PtrW'(push_len);
    count_d  = count_q + push_len - pop_len;
    if (clr) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage write: the first push_cnt lanes land at consecutive slots from wr.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (i < int'(push_cnt)) begin
          mem_q[PtrW'(wr_q + PtrW'(i))] <= push_hw[i];
        end
      end
    end
  end

  // Head and head+1 reads for instruction assembly.
  always_comb begin
    rd_nxt = rd_q + PtrW'(1);
    head0  = mem_q[rd_q];
    head1  = mem_q[rd_nxt];
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch realignment buffer: turns fetch words into one 16/32-bit instruction per cycle.
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 32,
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] RESET_ADDR  = 32'h0
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   flush,
  input  logic [31:0]            flush_addr,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [FETCH_WIDTH-1:0] fetch_data,
  input  logic                   fetch_error,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instr_data,
  output logic [31:0]            instr_addr,
  output logic                   instr_comp,
  output logic                   instr_error
);

  localparam int unsigned Hw       = FETCH_WIDTH / 16;
  localparam int unsigned SkipW    = $clog2(Hw);
  localparam int unsigned CntW     = $clog2(DEPTH + 1);
  localparam int unsigned LaneCntW = $clog2(Hw + 1);

  hword_t              head0, head1;
  hword_t [Hw-1:0]     lane_hw;
  logic [CntW-1:0]     count;
  logic [LaneCntW-1:0] push_cnt;
  logic [SkipW-1:0]    skip_q;
  logic [31:0]         pc_q;
  logic                push, pop, head_len2;
  logic                valid_c, comp_c, err_c;
  logic [31:0]         data_c;
  logic [31:0]         hold_data_q;
  logic                hold_comp_q, hold_err_q;

  // Space check uses the registered count only, so a same-cycle pop never credits.
  assign fetch_ready = (DEPTH - 32'(count)) >= Hw;
  assign push        = fetch_valid & fetch_ready & ~flush;
  assign pop         = valid_c & instr_ready & ~flush;
  assign push_cnt    = LaneCntW'(Hw) - LaneCntW'(skip_q);

  // Shift the fetch word down so the halfword at index skip lands in lane 0.
  always_comb begin
    lane_hw = '0;
    for (int i = 0; i < int'(Hw); i++) begin
      if (i + int'(skip_q) < int'(Hw)) begin
        lane_hw[i].hw  = fetch_data[(i + int'(skip_q)) * 16 +: 16];
        lane_hw[i].err = fetch_error;
      end
    end
  end

  fetch_hword_queue #(
    .DEPTH (DEPTH),
    .LANES (Hw)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push     (push),
    .push_cnt (push_cnt),
    .push_hw  (lane_hw),
    .pop      (pop),
    .pop_two  (head_len2),
    .head0    (head0),
    .head1    (head1),
    .count    (count)
  );

  // Head classification; an errored head goes out alone so it never stalls.
  always_comb begin
    head_len2 = is_rvi(head0.hw[1:0]) && !head0.err;
    comp_c    = !is_rvi(head0.hw[1:0]);
    if (head_len2) begin
      valid_c = count >= CntW'(2);
      data_c  = {head1.hw, head0.hw};
      err_c   = head1.err;
    end else begin
      valid_c = count != '0;
      data_c  = {16'h0, head0.hw};
      err_c   = head0.err;
    end
  end

  // PC and first-word skip tracking; flush overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_ADDR;
      skip_q <= RESET_ADDR[SkipW:1];
    end else if (flush) begin
      pc_q   <= flush_addr & ~32'h1;
      skip_q <= flush_addr[SkipW:1];
    end else begin
      if (push) skip_q <= '0;
      if (pop) pc_q <= pc_q + (head_len2 ? 32'd4 : 32'd2);
    end
  end

  // Keep the last presented instruction visible while nothing is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data_q <= '0;
      hold_comp_q <= 1'b0;
      hold_err_q  <= 1'b0;
    end else if (valid_c) begin
      hold_data_q <= data_c;
      hold_comp_q <= comp_c;
      hold_err_q  <= err_c;
    end
  end

  assign instr_valid = valid_c;
  assign instr_addr  = pc_q;
  assign instr_data  = valid_c ? data_c : hold_data_q;
  assign instr_comp  = valid_c ? comp_c : hold_comp_q;
  assign instr_error = valid_c ? err_c : hold_err_q;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench: directed fetch words, expected instructions queued, monitors compare.
module tb_fetch_align_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 32-bit fetch, 4-halfword queue.
  logic        a_fl = 0, a_fv = 0, a_fe = 0, a_ir = 1;
  logic [31:0] a_fa = '0, a_fd = '0;
  logic        a_fr, a_iv, a_ic, a_ie;
  logic [31:0] a_id, a_ia;

  // DUT B: 64-bit fetch, 8-halfword queue.
  logic        b_fl = 0, b_fv = 0, b_fe = 0, b_ir = 1;
  logic [31:0] b_fa = '0;
  logic [63:0] b_fd = '0;
  logic        b_fr, b_iv, b_ic, b_ie;
  logic [31:0] b_id, b_ia;

  fetch_align_buffer #(.FETCH_WIDTH(32), .DEPTH(4), .RESET_ADDR(32'h0)) dut_a (
    .rst(rst), .clk(clk), .flush(a_fl), .flush_addr(a_fa), .fetch_valid(a_fv),
    .fetch_ready(a_fr), .fetch_data(a_fd), .fetch_error(a_fe), .instr_valid(a_iv),
    .instr_ready(a_ir), .instr_data(a_id), .instr_addr(a_ia), .instr_comp(a_ic),
    .instr_error(a_ie)
  );

  fetch_align_buffer #(.FETCH_WIDTH(64), .DEPTH(8), .RESET_ADDR(32'h0)) dut_b (
    .rst(rst), .clk(clk), .flush(b_fl), .flush_addr(b_fa), .fetch_valid(b_fv),
    .fetch_ready(b_fr), .fetch_data(b_fd), .fetch_error(b_fe), .instr_valid(b_iv),
    .instr_ready(b_ir), .instr_data(b_id), .instr_addr(b_ia), .instr_comp(b_ic),
    .instr_error(b_ie)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        comp;
    logic        err;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [31:0] a, input logic c,
                              input logic e);
    exp_t x;
    x.data = d;
    x.addr = a;
    x.comp = c;
    x.err  = e;
    return x;
  endfunction

  // Monitor A: every accepted instruction must match the next expected one.
  always @(negedge clk) begin
    if (rst && a_iv && a_ir && !a_fl) begin
      if (exp_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected: got %h@%h expected none", a_id, a_ia);
      end else begin
        ea = exp_a.pop_front();
        check("a_data", a_id, ea.data);
        check("a_addr", a_ia, ea.addr);
        check("a_comp", 32'(a_ic), 32'(ea.comp));
        check("a_err", 32'(a_ie), 32'(ea.err));
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (rst && b_iv && b_ir && !b_fl) begin
      if (exp_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected: got %h@%h expected none", b_id, b_ia);
      end else begin
        eb = exp_b.pop_front();
        check("b_data", b_id, eb.data);
        check("b_addr", b_ia, eb.addr);
        check("b_comp", 32'(b_ic), 32'(eb.comp));
        check("b_err", 32'(b_ie), 32'(eb.err));
      end
    end
  end

  task automatic push_a(input logic [31:0] d, input logic e);
    @(posedge clk);
    #1;
    a_fv = 1;
    a_fd = d;
    a_fe = e;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (a_fr) begin
        @(posedge clk);
        #1;
        a_fv = 0;
        a_fe = 0;
        return;
      end
    end
    a_fv = 0;
    a_fe = 0;
    check("a_push_timeout", 32'(a_fr), 32'd1);
  endtask

  task automatic push_b(input logic [63:0] d);
    @(posedge clk);
    #1;
    b_fv = 1;
    b_fd = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (b_fr) begin
        @(posedge clk);
        #1;
        b_fv = 0;
        return;
      end
    end
    b_fv = 0;
    check("b_push_timeout", 32'(b_fr), 32'd1);
  endtask

  task automatic drain_a();
    for (int n = 0; n < 60 && exp_a.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("a_drain_left", 32'(exp_a.size()), 32'd0);
  endtask

  task automatic drain_b();
    for (int n = 0; n < 60 && exp_b.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("b_drain_left", 32'(exp_b.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_valid", 32'(a_iv), 32'd0);
    check("a_rst_data", a_id, 32'h0);
    check("a_rst_comp", 32'(a_ic), 32'd0);
    check("a_rst_err", 32'(a_ie), 32'd0);
    check("a_rst_ready", 32'(a_fr), 32'd1);
    check("a_rst_addr", a_ia, 32'h0);
    check("b_rst_valid", 32'(b_iv), 32'd0);
    check("b_rst_ready", 32'(b_fr), 32'd1);
    @(negedge clk);
    rst = 1;

    // Mixed 32-bit and compressed instructions.
    exp_a.push_back(mk(32'h00130513, 32'h0, 1'b0, 1'b0));
    exp_a.push_back(mk(32'h00004501, 32'h4, 1'b1, 1'b0));
    exp_a.push_back(mk(32'h00004505, 32'h6, 1'b1, 1'b0));
    push_a(32'h00130513, 1'b0);
    push_a(32'h45054501, 1'b0);
    drain_a();

    // 32-bit instruction straddling two fetch words waits for the second word.
    exp_a.push_back(mk(32'h00004501, 32'h8, 1'b1, 1'b0));
    push_a(32'h05134501, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("a_straddle_wait", 32'(a_iv), 32'd0);
    @(negedge clk);
    check("a_straddle_wait2", 32'(a_iv), 32'd0);
    exp_a.push_back(mk(32'h00130513, 32'hA, 1'b0, 1'b0));
    exp_a.push_back(mk(32'h00001234, 32'hE, 1'b1, 1'b0));
    push_a(32'h12340013, 1'b0);
    drain_a();

    // Flush with a word in the same cycle: word dropped, odd halfword skipped after.
    @(posedge clk);
    #1;
    a_fl = 1;
    a_fa = 32'h00000103;
    a_fv = 1;
    a_fd = 32'h00010001;
    @(posedge clk);
    #1;
    a_fl = 0;
    a_fv = 0;
    @(negedge clk);
    check("a_flush_valid", 32'(a_iv), 32'd0);
    @(negedge clk);
    check("a_flush_dropped", 32'(a_iv), 32'd0);
    check("a_flush_addr", a_ia, 32'h102);
    exp_a.push_back(mk(32'h00004505, 32'h102, 1'b1, 1'b0));
    push_a(32'h4505AAAA, 1'b0);
    exp_a.push_back(mk(32'h00000001, 32'h104, 1'b1, 1'b0));
    exp_a.push_back(mk(32'h00000001, 32'h106, 1'b1, 1'b0));
    push_a(32'h00010001, 1'b0);
    drain_a();

    // Backpressure with a 4-halfword queue.
    @(posedge clk);
    #1;
    a_ir = 0;
    exp_a.push_back(mk(32'h00130513, 32'h108, 1'b0, 1'b0));
    exp_a.push_back(mk(32'h00130513, 32'h10C, 1'b0, 1'b0));
    push_a(32'h00130513, 1'b0);
    push_a(32'h00130513, 1'b0);
    @(negedge clk);
    check("a_bp_full", 32'(a_fr), 32'd0);
    check("a_bp_hold_valid", 32'(a_iv), 32'd1);
    @(posedge clk);
    #1;
    a_ir = 1;
    @(negedge clk);
    check("a_bp_no_credit", 32'(a_fr), 32'd0);
    @(posedge clk);
    #1;
    a_ir = 0;
    @(negedge clk);
    check("a_bp_credit", 32'(a_fr), 32'd1);
    @(posedge clk);
    #1;
    a_ir = 1;
    drain_a();

    // Errored halfwords go out one at a time.
    exp_a.push_back(mk(32'h00000513, 32'h110, 1'b0, 1'b1));
    exp_a.push_back(mk(32'h00000013, 32'h112, 1'b0, 1'b1));
    push_a(32'h00130513, 1'b1);
    exp_a.push_back(mk(32'h00004501, 32'h114, 1'b1, 1'b0));
    exp_a.push_back(mk(32'h00004501, 32'h116, 1'b1, 1'b0));
    push_a(32'h45014501, 1'b0);
    drain_a();
    @(negedge clk);
    check("a_idle_valid", 32'(a_iv), 32'd0);
    check("a_idle_hold_data", a_id, 32'h00004501);
    check("a_idle_hold_comp", 32'(a_ic), 32'd1);
    check("a_idle_addr", a_ia, 32'h118);

    // 64-bit fetch: four c.nop on consecutive cycles.
    for (int i = 0; i < 4; i++) exp_b.push_back(mk(32'h00000001, 32'(2 * i), 1'b1, 1'b0));
    push_b(64'h0001000100010001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b_back_to_back", 32'(b_iv), 32'd1);
    end
    @(negedge clk);
    check("b_empty_after", 32'(b_iv), 32'd0);

    exp_b.push_back(mk(32'h00004501, 32'h8, 1'b1, 1'b0));
    exp_b.push_back(mk(32'h00130513, 32'hA, 1'b0, 1'b0));
    exp_b.push_back(mk(32'h00000000, 32'hE, 1'b1, 1'b0));
    push_b(64'h0000001305134501);
    drain_b();

    // Flush to the last halfword of a 64-bit word.
    @(posedge clk);
    #1;
    b_fl = 1;
    b_fa = 32'h00000106;
    @(posedge clk);
    #1;
    b_fl = 0;
    exp_b.push_back(mk(32'h00004505, 32'h106, 1'b1, 1'b0));
    push_b(64'h4505111122223333);
    drain_b();
    @(negedge clk);
    check("b_final_addr", b_ia, 32'h108);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
